// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light control unit: phase states, ALU opcodes,
// register-file map and one-hot light codes {red, yellow, green}.
package traffic_pkg;

  typedef enum logic [2:0] {
    INIT_ONE  = 3'd0,
    INIT_CNT  = 3'd1,
    NS_GREEN  = 3'd2,
    NS_YELLOW = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] REG_CNT = 2'd0;
  localparam logic [1:0] REG_ONE = 2'd1;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  function automatic state_t next_phase(input state_t s);
    case (s)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      default:   return NS_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_controller_fsm.sv
// Control unit for the traffic-light controller: sequences the light phases and
// drives the datapath register file / mux / ALU that holds the phase counter.
module traffic_controller_fsm
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       gt_2signal,
  input  logic       gt_6signal,
  output logic       sel_input,
  output logic [2:0] in_dtpath,
  output logic       REA,
  output logic       REB,
  output logic [1:0] RAA,
  output logic [1:0] RAB,
  output logic [1:0] WA,
  output logic       WEn,
  output logic [1:0] alu_sel,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light
);

  state_t state;
  state_t state_nx;
  logic   is_green;
  logic   limit;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT_ONE;
    else     state <= state_nx;
  end

  assign is_green = (state == NS_GREEN) || (state == EW_GREEN);
  assign limit    = is_green ? gt_6signal : gt_2signal;

  // Datapath controls are Mealy on tick/flags; everything is held quiet during reset.
  always_comb begin
    state_nx  = state;
    sel_input = 1'b0;
    in_dtpath = 3'd0;
    REA       = 1'b0;
    REB       = 1'b0;
    RAA       = 2'd0;
    RAB       = 2'd0;
    WA        = 2'd0;
    WEn       = 1'b0;
    alu_sel   = ALU_ADD;
    if (!rst) begin
      case (state)
        INIT_ONE: begin
          in_dtpath = 3'd1;
          WA        = REG_ONE;
          WEn       = 1'b1;
          state_nx  = INIT_CNT;
        end
        INIT_CNT: begin
          WA       = REG_CNT;
          WEn      = 1'b1;
          state_nx = NS_GREEN;
        end
        NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW: begin
          REA     = 1'b1;
          REB     = 1'b1;
          RAA     = REG_CNT;
          RAB     = REG_ONE;
          alu_sel = ALU_ADD;
          WA      = REG_CNT;
          WEn     = tick;
          // Clear and phase change share the limit tick's edge.
          if (tick) begin
            sel_input = !limit;
            if (limit) state_nx = next_phase(state);
          end
        end
        default: state_nx = INIT_ONE;
      endcase
    end
  end

  always_comb begin
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    if (!rst) begin
      case (state)
        NS_GREEN:  ns_light = LIGHT_GRN;
        NS_YELLOW: ns_light = LIGHT_YEL;
        EW_GREEN:  ew_light = LIGHT_GRN;
        EW_YELLOW: ew_light = LIGHT_YEL;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_controller_fsm.sv
// Bench for traffic_controller_fsm: a datapath register-file model closes the
// flag loop, and a phase-level model predicts every control and light output.
module tb_traffic_controller_fsm;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       gt_2signal, gt_6signal;
  logic       sel_input;
  logic [2:0] in_dtpath;
  logic       REA, REB;
  logic [1:0] RAA, RAB, WA;
  logic       WEn;
  logic [1:0] alu_sel;
  logic [2:0] ns_light, ew_light;

  int checks = 0;
  int errors = 0;

  traffic_controller_fsm dut (
    .clk(clk), .rst(rst), .tick(tick),
    .gt_2signal(gt_2signal), .gt_6signal(gt_6signal),
    .sel_input(sel_input), .in_dtpath(in_dtpath),
    .REA(REA), .REB(REB), .RAA(RAA), .RAB(RAB), .WA(WA), .WEn(WEn),
    .alu_sel(alu_sel), .ns_light(ns_light), .ew_light(ew_light)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: 4x3 register file, ALU add, comparators, optional flag override.
  logic [2:0] rf [4] = '{default: 3'd0};
  logic       force_en = 1'b0, f_gt2 = 1'b0, f_gt6 = 1'b0;
  logic [3:0] alu_res;
  logic       cap_wen, cap_sel;
  logic [1:0] cap_wa, cap_raa, cap_rab;
  logic [2:0] cap_ind;

  always_comb begin
    alu_res    = {1'b0, rf[RAA]} + {1'b0, rf[RAB]};
    gt_2signal = force_en ? f_gt2 : (alu_res > 4'd2);
    gt_6signal = force_en ? f_gt6 : (alu_res > 4'd6);
  end

  always @(posedge clk) begin
    if (cap_wen) rf[cap_wa] <= cap_sel ? (rf[cap_raa] + rf[cap_rab]) : cap_ind;
  end

  // Phase-level model: stage -2/-1 are the two init cycles, 0..3 index the phase tables.
  int         m_stage = -2;
  int         m_ticks = 0;
  logic [2:0] ns_tbl [4] = '{LIGHT_GRN, LIGHT_YEL, LIGHT_RED, LIGHT_RED};
  logic [2:0] ew_tbl [4] = '{LIGHT_RED, LIGHT_RED, LIGHT_GRN, LIGHT_YEL};
  int         dur_tbl [4] = '{7, 3, 7, 3};
  logic       m_lim;

  assign m_lim = (m_stage % 2 == 0) ? gt_6signal : gt_2signal;

  always @(posedge clk) begin
    if (rst) begin
      m_stage <= -2;
      m_ticks <= 0;
    end else if (m_stage < 0) begin
      m_stage <= m_stage + 1;
    end else if (tick) begin
      if (m_lim) begin
        if (!force_en) begin
          checks++;
          if (m_ticks + 1 != dur_tbl[m_stage]) begin
            errors++;
            $display("FAIL phase_len stage=%0d got %0d ticks want %0d", m_stage, m_ticks + 1, dur_tbl[m_stage]);
          end
        end
        m_stage <= (m_stage + 1) % 4;
        m_ticks <= 0;
      end else begin
        m_ticks <= m_ticks + 1;
      end
    end
  end

  // Per-cycle compare of every output against the model, plus run-length trackers.
  logic [20:0] act_v, exp_v;
  int run_g = 0, run_y = 0, last_g = 0, last_y = 0;

  always @(negedge clk) begin
    logic       e_sel, e_rea, e_reb, e_wen;
    logic [2:0] e_ind, e_ns, e_ew;
    logic [1:0] e_raa, e_rab, e_wa, e_alu;
    e_sel = 0; e_rea = 0; e_reb = 0; e_wen = 0; e_ind = 0;
    e_raa = 0; e_rab = 0; e_wa = 0; e_alu = ALU_ADD;
    e_ns = LIGHT_RED; e_ew = LIGHT_RED;
    if (!rst) begin
      if (m_stage == -2) begin
        e_ind = 3'd1; e_wa = REG_ONE; e_wen = 1;
      end else if (m_stage == -1) begin
        e_wa = REG_CNT; e_wen = 1;
      end else begin
        e_rea = 1; e_reb = 1; e_raa = REG_CNT; e_rab = REG_ONE; e_wa = REG_CNT;
        e_wen = tick; e_sel = tick && !m_lim;
        e_ns = ns_tbl[m_stage]; e_ew = ew_tbl[m_stage];
      end
    end
    exp_v = {e_sel, e_ind, e_rea, e_reb, e_raa, e_rab, e_wa, e_wen, e_alu, e_ns, e_ew};
    act_v = {sel_input, in_dtpath, REA, REB, RAA, RAB, WA, WEn, alu_sel, ns_light, ew_light};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL outputs t=%0t {sel,ind,rea,reb,raa,rab,wa,wen,alu,ns,ew} got %b want %b", $time, act_v, exp_v);
    end
    cap_wen = WEn; cap_sel = sel_input; cap_wa = WA; cap_raa = RAA; cap_rab = RAB; cap_ind = in_dtpath;
    if (ns_light == LIGHT_GRN) run_g++;
    else if (run_g > 0) begin last_g = run_g; run_g = 0; end
    if (ns_light == LIGHT_YEL) run_y++;
    else if (run_y > 0) begin last_y = run_y; run_y = 0; end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    int pos;
    bit found;
    logic [2:0] x_ns, x_ew;

    // Reset state
    @(negedge clk);
    chk("rst_wen", WEn, 0);
    chk("rst_lights", {ns_light, ew_light}, {LIGHT_RED, LIGHT_RED});
    chk("rst_ctrl", {sel_input, in_dtpath, REA, REB, WA}, 0);
    tick = 1'b1;
    do_reset(2);

    // Continuous tick: init, then a 20-cycle phase period starting at cycle 2
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      if (c == 0) chk("init_one_wr", {WEn, WA, in_dtpath, sel_input}, {1'b1, 2'd1, 3'd1, 1'b0});
      if (c == 1) chk("init_cnt_wr", {WEn, WA, in_dtpath, sel_input}, {1'b1, 2'd0, 3'd0, 1'b0});
      if (c == 2) chk("reg_one", rf[1], 1);
      if (c < 2) begin
        x_ns = LIGHT_RED; x_ew = LIGHT_RED;
      end else begin
        pos = (c - 2) % 20;
        x_ns = (pos < 7) ? LIGHT_GRN : (pos < 10) ? LIGHT_YEL : LIGHT_RED;
        x_ew = (pos >= 10 && pos < 17) ? LIGHT_GRN : (pos >= 17) ? LIGHT_YEL : LIGHT_RED;
        if (pos <= 7) chk($sformatf("cnt_c%0d", c), rf[0], (pos == 7) ? 0 : pos);
      end
      chk($sformatf("lights_c%0d", c), {ns_light, ew_light}, {x_ns, x_ew});
      step();
    end

    // Tick every third cycle: green 21 cycles, yellow 9 cycles
    do_reset(2);
    for (int c = 0; c < 140; c++) begin
      tick = (c % 3 == 0);
      step();
    end
    chk("slow_green_len", last_g, 21);
    chk("slow_yellow_len", last_y, 9);

    // Reset in EW_YELLOW with R0 = 2
    tick = 1'b1;
    do_reset(2);
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (ew_light == LIGHT_YEL && rf[0] == 3'd2) found = 1;
      else step();
    end
    chk("ew_yellow_reached", found, 1);
    #1 rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_lights", {ns_light, ew_light}, {LIGHT_RED, LIGHT_RED});
    chk("midrst_init_one", {WEn, WA, in_dtpath}, {1'b1, 2'd1, 3'd1});
    step(); step();
    @(negedge clk);
    chk("midrst_cnt_cleared", rf[0], 0);
    chk("midrst_ns_green", ns_light, LIGHT_GRN);

    // Forced flags in NS_GREEN: gt_2signal alone must not advance, gt_6signal does
    force_en = 1'b1; f_gt2 = 1'b1; f_gt6 = 1'b0;
    repeat (4) begin
      step();
      @(negedge clk);
      chk("gt2_only_holds", ns_light, LIGHT_GRN);
    end
    step();
    f_gt6 = 1'b1;
    @(negedge clk);
    chk("both_flags_clear_sel", {WEn, sel_input, in_dtpath}, {1'b1, 1'b0, 3'd0});
    step();
    force_en = 1'b0; f_gt2 = 1'b0; f_gt6 = 1'b0;
    @(negedge clk);
    chk("both_flags_advance", ns_light, LIGHT_YEL);
    chk("both_flags_cnt", rf[0], 0);

    // Random ticks with occasional resets; the per-cycle compare does the checking
    do_reset(1);
    for (int c = 0; c < 500; c++) begin
      tick = $urandom_range(0, 1);
      rst  = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;
    tick = 1'b1;
    repeat (30) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_controller_fsm.md
# traffic_controller_fsm

Control unit for the traffic-light controller. It drives the `datapath` block's register-file, mux and ALU controls, and it sequences the two-direction light phases from the datapath's `gt_2signal` and `gt_6signal` status flags. All phase timing is counted inside the datapath register file; this block holds only the phase state. It sits beside `datapath` in the controller top level and connects to it pin-for-pin.

## Interface
Parameters: none. Constants live in `traffic_pkg`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  time-base strobe; one count per cycle in which it is high.
- `gt_2signal`  in  1  from datapath; ALU result > 2.
- `gt_6signal`  in  1  from datapath; ALU result > 6.
- `sel_input`  out  1  datapath write mux: 0 = `in_dtpath`, 1 = ALU result.
- `in_dtpath`  out  3  constant to write.
- `REA`, `REB`  out  1 each  register-file read enables.
- `RAA`, `RAB`  out  2 each  read addresses.
- `WA`  out  2  write address.
- `WEn`  out  1  register-file write enable.
- `alu_sel`  out  2  ALU operation.
- `ns_light`, `ew_light`  out  3 each  one-hot {red, yellow, green}.

## Operation
- Register map: R0 = phase counter (`REG_CNT`); R1 = constant 1 (`REG_ONE`). R2 and R3 are unused.
- States: `INIT_ONE`, `INIT_CNT`, `NS_GREEN`, `NS_YELLOW`, `EW_GREEN`, `EW_YELLOW`.
- `INIT_ONE`:
  - Write R1 = 3'd1 (`sel_input`=0, `in_dtpath`=1, `WA`=1, `WEn`=1).
  - Go to `INIT_CNT` unconditionally.
- `INIT_CNT`:
  - Write R0 = 0.
  - Go to `NS_GREEN`.
- Count states (all four), control outputs:
  - `REA`=`REB`=1, `RAA`=0, `RAB`=1, `alu_sel`=`ALU_ADD`, `WA`=0.
  - `WEn`=`tick`.
- Count states, write and transition on each `tick`:
  - The `tick` cycle writes R0+1 (`sel_input`=1) if the limit flag is low.
  - If the limit flag is high, it writes 0 (`sel_input`=0, `in_dtpath`=0) and advances the state.
- Limit flags: green states use `gt_6signal`; yellow states use `gt_2signal`.
- Phase order: `NS_GREEN` → `NS_YELLOW` → `EW_GREEN` → `EW_YELLOW` → `NS_GREEN`.
- Lights (Moore, decoded from state):
  - `NS_GREEN`: ns = green, ew = red.
  - `NS_YELLOW`: ns = yellow, ew = red.
  - EW phases mirror the NS phases.
  - Init states: both red (3'b100).
- Datapath controls are Mealy (combinational from state, `tick`, flags). `tick` low means `WEn`=0 and the state holds.
- Arithmetic: 3-bit counter. The maximum value written is 6 in green and 2 in yellow, so the counter never wraps.

## Timing
- Reset: state = `INIT_ONE`. While `rst` is high, `WEn`=0 and both lights are red.
- All other controls are 0 during reset.
- Reset mid-phase takes effect at the next edge. The counter is reinitialised through the init states.
- Init takes 2 cycles, independent of `tick`.
- Green lasts exactly 7 ticks (writes 1..6, then clear on the 7th). Yellow lasts exactly 3 ticks.
- With `tick` tied high, the full cycle is 20 cycles. The first `NS_GREEN` cycle is cycle 2 after reset release.
- The clear and the state change occur on the same edge; no extra clear cycle.
- Combinational path: datapath read → ALU → comparator → `sel_input`. This must close in one cycle.

## Structure
- `traffic_pkg` holds:
  - state enum;
  - `ALU_ADD` (2'b00) and the remaining ALU opcodes;
  - `REG_CNT`, `REG_ONE`;
  - light codes `LIGHT_RED`/`LIGHT_YEL`/`LIGHT_GRN`.
- Single module: state register, next-state/control logic, light decode. No sub-module.

## Test plan
- Reset, then release with `tick`=1:
  - Cycle 0 writes R1=1.
  - Cycle 1 writes R0=0.
  - Lights are 100/100 through cycle 1, then ns=001, ew=100.
- `tick`=1 continuous in `NS_GREEN`:
  - R0 goes 1..6.
  - The 7th tick writes 0 and ns becomes 010.
- `NS_YELLOW`: 3 ticks, then ns=100 and ew=001. A full cycle returns to `NS_GREEN` after 20 ticks.
- `tick` toggled every 3rd cycle: phase lengths scale to 21/9 cycles, and `WEn` is high only on tick cycles.
- `rst` asserted mid-`EW_YELLOW` with R0=2: next cycle is `INIT_ONE` with lights 100/100, and R0 is reinitialised to 0.
- Both flags forced high in `NS_GREEN`: only `gt_6signal` matters. Forcing `gt_2signal` alone must not advance green.
